// File: rtl/prefetch_ctrl.sv
// Next-line L2 prefetcher: demand/stream triggers feed a 2-entry candidate queue,
// one outstanding prefetch at a time fills a single-line buffer snooped by demand reads.
module prefetch_ctrl #(
  parameter int unsigned STRIDE_LINES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pf_enable,
  input  logic         L2_read,
  input  logic         L2_write,
  input  logic [31:0]  L2_addr,
  input  logic         L2_arb_resp,
  output logic         pre_read,
  output logic [31:0]  pre_addr,
  input  logic         arb_pre_resp,
  input  logic [255:0] arb_pre_rdata,
  output logic         pf_hit,
  output logic [255:0] pf_rdata,
  output logic [7:0]   pf_drops
);

  localparam logic [26:0] Stride = 27'(STRIDE_LINES);

  typedef enum logic {StIdle, StReq} state_e;

  state_e             state_q, state_d;
  logic [1:0][26:0]   q_addr_q, q_addr_d;
  logic [1:0]         q_valid_q, q_valid_d;
  logic [1:0]         q_cnt_q, q_cnt_d;
  logic [26:0]        inflight_q, inflight_d;
  logic               stale_q, stale_d;
  logic [26:0]        buf_addr_q, buf_addr_d;
  logic [255:0]       buf_data_q, buf_data_d;
  logic               buf_valid_q, buf_valid_d;
  logic               hit_q, hit_d;
  logic [7:0]         drops_q, drops_d;

  logic [26:0] dem_line, cand;
  logic        demand_trig, stream_trig, cand_vld, cand_dup;
  logic        resp_done, head_ok, issue, pop, stale_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      q_addr_q    <= '0;
      q_valid_q   <= '0;
      q_cnt_q     <= '0;
      inflight_q  <= '0;
      stale_q     <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      drops_q     <= '0;
    end else begin
      state_q     <= state_d;
      q_addr_q    <= q_addr_d;
      q_valid_q   <= q_valid_d;
      q_cnt_q     <= q_cnt_d;
      inflight_q  <= inflight_d;
      stale_q     <= stale_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
      hit_q       <= hit_d;
      drops_q     <= drops_d;
    end
  end

  // Trigger and candidate generation
  always_comb begin
    dem_line    = L2_addr[31:5];
    pf_hit      = pf_enable & L2_read & buf_valid_q & (dem_line == buf_addr_q);
    hit_d       = pf_hit;
    demand_trig = pf_enable & L2_read & L2_arb_resp;
    stream_trig = pf_enable & pf_hit & ~hit_q;
    cand_vld    = demand_trig | stream_trig;
    cand        = demand_trig ? dem_line + Stride : buf_addr_q + Stride;
    cand_dup    = (buf_valid_q & (cand == buf_addr_q)) |
                  (q_valid_q[0] & (cand == q_addr_q[0])) |
                  (q_valid_q[1] & (cand == q_addr_q[1])) |
                  ((state_q == StReq) & (cand == inflight_q));
    resp_done   = (state_q == StReq) & arb_pre_resp;
    head_ok     = (q_cnt_q != 2'd0) & q_valid_q[0] & pf_enable;
    issue       = (state_q == StIdle) & head_ok & ~L2_read & ~L2_write;
    // Invalidated heads drain one per cycle while idle; the in-flight head pops on completion.
    pop         = (resp_done & (q_cnt_q != 2'd0)) |
                  ((state_q == StIdle) & (q_cnt_q != 2'd0) & ~head_ok);
    stale_now   = stale_q | (L2_write & (dem_line == inflight_q));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (issue) state_d = StReq;
      StReq:  if (arb_pre_resp) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pre_read = (state_q == StReq);
    pre_addr = (state_q == StReq) ? {inflight_q, 5'b0} : {buf_addr_q, 5'b0};
    pf_rdata = buf_data_q;
    pf_drops = drops_q;
  end

  // Queue, in-flight tracking and buffer update
  always_comb begin
    q_addr_d  = q_addr_q;
    q_valid_d = q_valid_q;
    q_cnt_d   = q_cnt_q;
    drops_d   = drops_q;
    for (int i = 0; i < 2; i++) begin
      if (L2_write && (dem_line == q_addr_q[i])) q_valid_d[i] = 1'b0;
    end
    if (!pf_enable) q_valid_d = '0;
    if (pop) begin
      q_addr_d[0] = q_addr_d[1];
      q_valid_d   = {1'b0, q_valid_d[1]};
      q_cnt_d     = q_cnt_d - 2'd1;
    end
    if (cand_vld && !cand_dup) begin
      if (q_cnt_d != 2'd2) begin
        q_addr_d[q_cnt_d[0]]  = cand;
        q_valid_d[q_cnt_d[0]] = 1'b1;
        q_cnt_d               = q_cnt_d + 2'd1;
      end else if (drops_q != 8'hff) begin
        drops_d = drops_q + 8'd1;
      end
    end

    inflight_d = issue ? q_addr_q[0] : inflight_q;
    stale_d    = stale_q;
    if (issue) stale_d = 1'b0;
    else if ((state_q == StReq) && stale_now) stale_d = 1'b1;

    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
    if (L2_write && (dem_line == buf_addr_q)) buf_valid_d = 1'b0;
    if (resp_done && !stale_now) begin
      buf_addr_d  = inflight_q;
      buf_data_d  = arb_pre_rdata;
      buf_valid_d = 1'b1;
    end
  end

endmodule
